// File: rtl/sm_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package sm_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    DONE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         LEN_W         = 16;
  localparam int         WORD_W        = 32;

endpackage

// File: rtl/sm_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface sm_imem_loader_if;
  import sm_loader_pkg::*;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              im_we;
  logic [WORD_W-1:0] im_wa;
  logic [WORD_W-1:0] im_wd;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_wa, im_wd
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_wa, im_wd
  );
endinterface

// File: rtl/sm_loader_word_asm.sv
// Collects four bytes little-endian; word_next is the full word in the cycle the 4th byte arrives.
module sm_loader_word_asm
  import sm_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        din,
  output logic              ready,
  output logic [WORD_W-1:0] word_next
);

  logic [1:0]  bcnt;
  logic [23:0] sh;

  always_ff @(posedge clk) begin
    if (rst || clr) bcnt <= '0;
    else if (en)    bcnt <= bcnt + 2'd1;
  end

  // Only the three earlier bytes are stored; the 4th is taken straight from din.
  always_ff @(posedge clk) begin
    if (en) sh <= {din, sh[23:8]};
  end

  assign word_next = {din, sh};
  assign ready     = en && (bcnt == 2'd3);

endmodule

// File: rtl/sm_imem_loader.sv
// Boot loader: parses SYNC/LEN/DATA/CSUM frames, writes instruction memory, releases CPU reset on success.
module sm_imem_loader
  import sm_loader_pkg::*;
#(
  parameter int unsigned SIZE      = 64,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  sm_imem_loader_if.slave     bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_t             state, state_n;
  logic [7:0]         len_lo;
  logic [7:0]         xsum;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_now;
  logic [LEN_W-1:0]   word_cnt;
  logic               accept;
  logic               sync_hit;
  logic               len_bad;
  logic               asm_ready;
  logic [WORD_W-1:0]  asm_word;

  assign bus.rx_ready = (state != WRITE);
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign sync_hit     = accept && (bus.rx_data == SYNC_BYTE) &&
                        ((state == IDLE) || (state == DONE));
  assign len_now      = {bus.rx_data, len_lo};
  assign len_bad      = (len_now == '0) || (32'(len_now) > SIZE);

  sm_loader_word_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == LEN1),
    .en        (accept && (state == DATA)),
    .din       (bus.rx_data),
    .ready     (asm_ready),
    .word_next (asm_word)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (sync_hit) state_n = LEN0;
      LEN0:       if (accept) state_n = LEN1;
      LEN1:       if (accept) state_n = len_bad ? IDLE : DATA;
      DATA:       if (asm_ready) state_n = WRITE;
      WRITE:      state_n = (word_cnt + 16'd1 == len) ? CSUM : DATA;
      CSUM:       if (accept) state_n = (bus.rx_data == xsum) ? DONE : IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bus.im_we <= 1'b0;
      bus.im_wa <= '0;
      bus.im_wd <= '0;
      cpu_rst  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      word_cnt <= '0;
      xsum     <= '0;
    end else begin
      state     <= state_n;
      bus.im_we <= 1'b0;
      case (state)
        IDLE, DONE: if (sync_hit) begin
          busy    <= 1'b1;
          error   <= 1'b0;
          done    <= 1'b0;
          cpu_rst <= 1'b1;
          xsum    <= '0;
        end
        LEN0: if (accept) xsum <= xsum ^ bus.rx_data;
        LEN1: if (accept) begin
          xsum     <= xsum ^ bus.rx_data;
          word_cnt <= '0;
          if (len_bad) begin
            error <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DATA: if (accept) begin
          xsum <= xsum ^ bus.rx_data;
          if (asm_ready) begin
            bus.im_we <= 1'b1;
            bus.im_wa <= 32'(word_cnt);
            bus.im_wd <= asm_word;
          end
        end
        WRITE: word_cnt <= word_cnt + 16'd1;
        CSUM: if (accept) begin
          busy <= 1'b0;
          if (bus.rx_data == xsum) begin
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end else begin
            error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Length fields are plain data and need no reset.
  always_ff @(posedge clk) begin
    if (accept && (state == LEN0)) len_lo <= bus.rx_data;
    if (accept && (state == LEN1)) len    <= len_now;
  end

endmodule

// File: tb/tb_sm_imem_loader.sv
// Directed bench for sm_imem_loader with a frame-level reference model checked every cycle.
module tb_sm_imem_loader;
  import sm_loader_pkg::*;

  localparam int unsigned SIZE = 64;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, busy, done, error;

  sm_imem_loader_if bus ();

  sm_imem_loader #(.SIZE(SIZE), .SYNC_BYTE(SYNC)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level model: fi = index within current frame, -1 while hunting for SYNC.
  int          fi = -1;
  int          mlen = 0;
  logic [7:0]  mx = '0;
  logic [31:0] mcur = '0;
  logic        e_we = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_cpu = 1'b1;
  logic [31:0] e_wa = '0, e_wd = '0;
  logic        started = 1'b0;

  logic [31:0] wa_log[$];
  logic [31:0] wd_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int d, k;
    if (fi < 0) begin
      if (b == SYNC) begin
        fi = 0; e_busy = 1; e_err = 0; e_done = 0; e_cpu = 1; mx = '0;
      end
    end else if (fi == 0) begin
      mlen = int'(b); mx ^= b; fi = 1;
    end else if (fi == 1) begin
      mlen = mlen + 256 * int'(b); mx ^= b;
      if (mlen == 0 || mlen > int'(SIZE)) begin
        e_err = 1; e_busy = 0; fi = -1;
      end else fi = 2;
    end else if (fi < 2 + 4 * mlen) begin
      d = fi - 2; k = d % 4;
      if (k == 0) mcur = '0;
      mcur[8*k +: 8] = b;
      mx ^= b;
      if (k == 3) begin
        e_we = 1; e_wa = 32'(d / 4); e_wd = mcur;
      end
      fi++;
    end else begin
      e_busy = 0;
      if (b == mx) begin e_done = 1; e_cpu = 0; end
      else e_err = 1;
      fi = -1;
    end
  endtask

  // Update model on each active edge, compare on the following falling edge.
  initial begin
    logic r, a;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      r = rst;
      a = bus.rx_valid && bus.rx_ready;
      b = bus.rx_data;
      if (r) begin
        started = 1; fi = -1; e_we = 0; e_wa = '0; e_wd = '0;
        e_busy = 0; e_done = 0; e_err = 0; e_cpu = 1;
      end else if (started) begin
        e_we = 0;
        if (a) model_byte(b);
      end
      @(negedge clk);
      if (started) begin
        chk("im_we", 32'(bus.im_we), 32'(e_we));
        chk("im_wa", bus.im_wa, e_wa);
        chk("im_wd", bus.im_wd, e_wd);
        chk("rx_ready", 32'(bus.rx_ready), 32'(!e_we));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(error), 32'(e_err));
        chk("cpu_rst", 32'(cpu_rst), 32'(e_cpu));
        if (bus.im_we) begin
          wa_log.push_back(bus.im_wa);
          wd_log.push_back(bus.im_wd);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    forever begin
      @(posedge clk);
      if (bus.rx_ready) break;
      n++;
      if (n > 20) begin
        n_chk++; n_fail++;
        $display("FAIL handshake: byte %h not accepted after %0d cycles, expected acceptance", b, n);
        break;
      end
    end
    #1;
  endtask

  task automatic idle(input int cyc);
    bus.rx_valid = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bq_t f, input bit rnd);
    wa_log.delete();
    wd_log.delete();
    foreach (f[i]) send_byte(f[i], rnd ? int'($urandom_range(0, 5)) : 0);
    idle(3);
  endtask

  task automatic status(input string tag, input logic d, input logic e, input logic bz, input logic c);
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".error"}, 32'(error), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(c));
  endtask

  task automatic good_writes(input string tag);
    chk({tag, ".nwr"}, 32'(wa_log.size()), 32'd2);
    if (wa_log.size() == 2) begin
      chk({tag, ".wa0"}, wa_log[0], 32'd0);
      chk({tag, ".wd0"}, wd_log[0], 32'h00500093);
      chk({tag, ".wa1"}, wa_log[1], 32'd1);
      chk({tag, ".wd1"}, wd_log[1], 32'h00100113);
    end
  endtask

  initial begin
    bq_t good, bad, big, part, tail;
    logic [7:0] x;
    good = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
             8'h13, 8'h01, 8'h10, 8'h00, 8'hC3};
    bad  = good;
    bad[11] = 8'hC4;

    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    status("reset", 0, 0, 0, 1);
    chk("reset.im_we", 32'(bus.im_we), 32'd0);
    chk("reset.im_wa", bus.im_wa, 32'd0);
    chk("reset.im_wd", bus.im_wd, 32'd0);

    // Garbage ahead of a valid frame, then the good frame itself.
    send_frame('{8'h00, 8'hFF, 8'h5A, 8'h13}, 1'b0);
    chk("garbage.nwr", 32'(wa_log.size()), 32'd0);
    send_frame(good, 1'b0);
    good_writes("good");
    status("good", 1, 0, 0, 0);

    // Reload from DONE: SYNC must re-assert cpu_rst before the rest arrives.
    wa_log.delete(); wd_log.delete();
    send_byte(SYNC, 0);
    chk("reload.cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload.done", 32'(done), 32'd0);
    tail = bad;
    void'(tail.pop_front());
    foreach (tail[i]) send_byte(tail[i], 0);
    idle(3);
    good_writes("badcsum");
    status("badcsum", 0, 1, 0, 1);

    send_frame(good, 1'b0);
    good_writes("recover");
    status("recover", 1, 0, 0, 0);

    send_frame('{8'hA5, 8'h00, 8'h00}, 1'b0);
    chk("len0.nwr", 32'(wa_log.size()), 32'd0);
    status("len0", 0, 1, 0, 1);

    send_frame('{8'hA5, 8'h41, 8'h00}, 1'b0);
    chk("len65.nwr", 32'(wa_log.size()), 32'd0);
    status("len65", 0, 1, 0, 1);

    big = '{8'hA5, 8'h40, 8'h00};
    x = 8'h40;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++) begin
        big.push_back(8'(i));
        x ^= 8'(i);
      end
    big.push_back(x);
    send_frame(big, 1'b0);
    chk("len64.nwr", 32'(wa_log.size()), 32'd64);
    if (wa_log.size() == 64) begin
      chk("len64.wa63", wa_log[63], 32'd63);
      chk("len64.wd63", wd_log[63], 32'h3F3F3F3F);
      chk("len64.wd5", wd_log[5], 32'h05050505);
    end
    status("len64", 1, 0, 0, 0);

    // Random inter-byte gaps, valid otherwise held across WRITE cycles.
    send_frame(good, 1'b1);
    good_writes("gaps");
    status("gaps", 1, 0, 0, 0);

    // Reset in the middle of a frame, after six data bytes.
    part = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
    foreach (part[i]) send_byte(part[i], 0);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    status("midrst", 0, 0, 0, 1);
    chk("midrst.im_we", 32'(bus.im_we), 32'd0);
    chk("midrst.im_wa", bus.im_wa, 32'd0);
    chk("midrst.im_wd", bus.im_wd, 32'd0);
    send_frame(good, 1'b0);
    good_writes("afterrst");
    status("afterrst", 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sm_imem_loader.md
Name: sm_imem_loader

Overview:
- Boot loader that fills the CPU instruction memory.
- Receives a framed byte stream (from the UART RX byte interface) and assembles little-endian 32-bit instruction words.
- Drives the write port of the instruction memory; the CPU fetch side is the asynchronous read port of the same memory.
- Holds the CPU in reset until a complete, checksum-valid image is written.

Parameters:
SIZE, 64, instruction memory depth in 32-bit words; maximum accepted word count
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_valid  input  1  byte available on rx_data
rx_data  input  8  received byte
rx_ready  output  1  loader accepts byte this cycle
im_we  output  1  instruction memory write strobe, one cycle per word
im_wa  output  32  word index (not byte address) for the write
im_wd  output  32  instruction word to write
cpu_rst  output  1  active-high hold of CPU reset
busy  output  1  frame in progress
done  output  1  last frame loaded and verified
error  output  1  last frame rejected; sticky

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Handshake: a byte is consumed when rx_valid && rx_ready at the clk edge.
  - rx_ready=1 in every state except WRITE.
  - A producer holding rx_valid through WRITE loses no byte.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*N data bytes, then CSUM.
  - N = {LEN_HI,LEN_LO} words.
  - Data bytes are little-endian per word.
  - CSUM = XOR of all bytes from LEN_LO through the last data byte.
- Reset values: state IDLE, im_we=0, im_wa=0, im_wd=0, cpu_rst=1, busy=0, done=0, error=0; word and byte counters 0; running XOR 0.
- States:
  - IDLE: bytes other than SYNC_BYTE are discarded. SYNC_BYTE -> LEN0, with busy=1, error=0, xor=0.
  - LEN0: capture LEN_LO, xor^=byte -> LEN1.
  - LEN1: capture LEN_HI, xor^=byte.
    - If N==0 or N>SIZE: error=1, busy=0 -> IDLE.
    - Otherwise -> DATA with word=0, byte=0.
  - DATA: byte k (0..3) goes into im_wd[8k+7:8k], xor^=byte. On k==3 -> WRITE.
  - WRITE: lasts one cycle, im_we=1, im_wa=word.
    - Then word+1. If word+1==N -> CSUM, else -> DATA with byte=0.
    - Write latency: im_we is asserted in the cycle after the 4th byte is accepted.
  - CSUM:
    - Byte == xor: done=1, cpu_rst=0, busy=0 -> DONE.
    - Byte != xor: error=1, busy=0, cpu_rst stays 1 -> IDLE.
  - DONE: non-sync bytes are discarded. SYNC_BYTE: done=0, cpu_rst=1, then behave as in IDLE (reload).
- cpu_rst is asserted from reset until the first successful CSUM and remains asserted after any error.
- im_wd/im_wa hold their last values when im_we=0.
- Reset mid-frame returns all state to reset values. Already-written words stay in memory (no erase).
- The word counter never wraps: N<=SIZE is checked before DATA.

Decomposition:
- Shared package sm_loader_pkg holds:
  - state enum: IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE
  - SYNC_BYTE default
  - frame field widths (16-bit length)
- One sub-module is natural: sm_loader_word_asm, a 4-byte little-endian shift assembler with byte counter and word-ready flag.
- FSM, counters, checksum and outputs stay in the top.

Test Plan:
- Good load, SIZE=64: A5 02 00 93 00 50 00 13 01 10 00 C3 -> im_we at wa=0 wd=0x00500093, then wa=1 wd=0x00100113; then done=1, cpu_rst=0, error=0, busy=0.
- Same frame with CSUM=C4 -> both writes occur; error=1, done=0, cpu_rst=1; FSM in IDLE; a following correct frame sets done=1 and clears error.
- Garbage 00 FF 5A 13 before the good frame -> no im_we for garbage; result identical to the good-load case.
- Length checks: A5 00 00 -> error=1, no im_we. A5 41 00 (65 > SIZE) -> error=1, no im_we. A5 40 00 (64 words) -> accepted, last write at wa=63.
- Flow control: rx_valid held continuously, including through WRITE cycles, plus random 0-5 cycle gaps -> every byte consumed exactly once; writes match the good-load case.
- Reset behaviour:
  - rst pulse after 6 data bytes -> all outputs at reset values, cpu_rst=1; a subsequent full frame loads correctly.
  - After DONE, sending A5 -> cpu_rst=1, done=0; reload proceeds.
